// File: rtl/alu_result_checker.sv
// Compares the registered outputs of a reference ALU and an ALU under test over a
// programmed run of samples, counting mismatches and capturing the first failure.
module alu_result_checker #(
    parameter int W   = 32,
    parameter int N_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] num_vectors,
    input  logic [7:0]     c_out_check_mask,
    input  logic           sample_valid,
    input  logic [2:0]     operation,
    input  logic [W-1:0]   result_dut,
    input  logic           c_out_dut,
    input  logic [W-1:0]   result_verify,
    input  logic           c_out_verify,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [N_W-1:0] vector_count,
    output logic [N_W-1:0] fail_count,
    output logic [N_W-1:0] first_fail_index,
    output logic [2:0]     first_fail_op,
    output logic [W-1:0]   first_fail_expected,
    output logic [W-1:0]   first_fail_actual
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [N_W-1:0] ONE = {{(N_W-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_next;

    logic [N_W-1:0] r_num_vectors;
    logic [7:0]     r_mask;
    logic [N_W-1:0] r_vector_count;
    logic [N_W-1:0] r_fail_count;
    logic [N_W-1:0] r_ff_index;
    logic [2:0]     r_ff_op;
    logic [W-1:0]   r_ff_expected;
    logic [W-1:0]   r_ff_actual;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;

    logic           w_start_ok;
    logic           w_accept;
    logic           w_mismatch;
    logic           w_last;
    logic           w_capture;
    logic [N_W-1:0] w_nv_minus1;
    logic [N_W-1:0] w_vc_next;
    logic [N_W-1:0] w_fc_next;

    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_accept    = sample_valid && (r_state == S_RUN);
    assign w_mismatch  = (result_dut != result_verify) ||
                         (r_mask[operation] && (c_out_dut != c_out_verify));
    assign w_nv_minus1 = r_num_vectors - ONE;
    assign w_last      = (r_vector_count == w_nv_minus1);
    // Only the first failure of a run is kept; fail_count never wraps back to 0.
    assign w_capture   = w_accept && w_mismatch && (r_fail_count == '0);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = (num_vectors == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (sample_valid && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_vc_next = r_vector_count;
        w_fc_next = r_fail_count;
        if (w_start_ok) begin
            w_vc_next = '0;
            w_fc_next = '0;
        end else if (w_accept) begin
            w_vc_next = r_vector_count + ONE;
            if (w_mismatch && !(&r_fail_count)) begin
                w_fc_next = r_fail_count + ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_vectors  <= '0;
            r_mask         <= '0;
            r_vector_count <= '0;
            r_fail_count   <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_num_vectors <= num_vectors;
                r_mask        <= c_out_check_mask;
            end
            r_vector_count <= w_vc_next;
            r_fail_count   <= w_fc_next;
            r_busy         <= (w_state_next == S_RUN);
            r_done         <= (w_state_next == S_DONE);
            r_pass         <= (w_state_next == S_DONE) && (w_fc_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_index    <= '0;
            r_ff_op       <= '0;
            r_ff_expected <= '0;
            r_ff_actual   <= '0;
        end else if (w_start_ok) begin
            r_ff_index    <= '0;
            r_ff_op       <= '0;
            r_ff_expected <= '0;
            r_ff_actual   <= '0;
        end else if (w_capture) begin
            r_ff_index    <= r_vector_count;
            r_ff_op       <= operation;
            r_ff_expected <= result_verify;
            r_ff_actual   <= result_dut;
        end
    end

    assign busy                = r_busy;
    assign done                = r_done;
    assign pass                = r_pass;
    assign vector_count        = r_vector_count;
    assign fail_count          = r_fail_count;
    assign first_fail_index    = r_ff_index;
    assign first_fail_op       = r_ff_op;
    assign first_fail_expected = r_ff_expected;
    assign first_fail_actual   = r_ff_actual;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: a run-level model (list of accepted samples per run)
// is compared against the DUT every cycle, plus directed literal expectations.
module tb_alu_result_checker;

    localparam int W   = 32;
    localparam int N_W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N_W-1:0] num_vectors;
    logic [7:0]     c_out_check_mask;
    logic           sample_valid;
    logic [2:0]     operation;
    logic [W-1:0]   result_dut;
    logic           c_out_dut;
    logic [W-1:0]   result_verify;
    logic           c_out_verify;
    logic           busy;
    logic           done;
    logic           pass;
    logic [N_W-1:0] vector_count;
    logic [N_W-1:0] fail_count;
    logic [N_W-1:0] first_fail_index;
    logic [2:0]     first_fail_op;
    logic [W-1:0]   first_fail_expected;
    logic [W-1:0]   first_fail_actual;

    alu_result_checker #(.W(W), .N_W(N_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .num_vectors         (num_vectors),
        .c_out_check_mask    (c_out_check_mask),
        .sample_valid        (sample_valid),
        .operation           (operation),
        .result_dut          (result_dut),
        .c_out_dut           (c_out_dut),
        .result_verify       (result_verify),
        .c_out_verify        (c_out_verify),
        .busy                (busy),
        .done                (done),
        .pass                (pass),
        .vector_count        (vector_count),
        .fail_count          (fail_count),
        .first_fail_index    (first_fail_index),
        .first_fail_op       (first_fail_op),
        .first_fail_expected (first_fail_expected),
        .first_fail_actual   (first_fail_actual)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- run-level model ----------------
    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] rd;
        logic [W-1:0] rv;
        logic         cd;
        logic         cv;
    } smp_t;

    typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;

    mphase_t m_phase;
    int      m_nv;
    logic [7:0] m_mask;
    smp_t    m_run[$];

    function automatic bit is_fail(smp_t s, logic [7:0] mask);
        return (s.rd != s.rv) || (mask[s.op] && (s.cd != s.cv));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_nv    = 0;
            m_mask  = '0;
            m_run.delete();
        end else if (m_phase != M_RUN && start) begin
            m_run.delete();
            m_nv    = int'(num_vectors);
            m_mask  = c_out_check_mask;
            m_phase = (m_nv == 0) ? M_DONE : M_RUN;
        end else if (m_phase == M_RUN && sample_valid) begin
            m_run.push_back('{operation, result_dut, result_verify, c_out_dut, c_out_verify});
            if (m_run.size() == m_nv) m_phase = M_DONE;
        end
    end

    // Compare process: derives every output from the list of samples in the run.
    always @(negedge clk) begin
        if (rst_n) begin
            int   fails;
            int   first;
            logic [63:0] e_fc;
            fails = 0;
            first = -1;
            foreach (m_run[i]) begin
                if (is_fail(m_run[i], m_mask)) begin
                    if (first < 0) first = i;
                    fails++;
                end
            end
            e_fc = (fails > 65535) ? 64'd65535 : 64'(fails);
            check("m_busy", busy, m_phase == M_RUN);
            check("m_done", done, m_phase == M_DONE);
            check("m_pass", pass, m_phase == M_DONE && fails == 0);
            check("m_vector_count", vector_count, 64'(m_run.size()));
            check("m_fail_count", fail_count, e_fc);
            check("m_ff_index", first_fail_index, (first < 0) ? 64'd0 : 64'(first));
            check("m_ff_op", first_fail_op, (first < 0) ? 64'd0 : 64'(m_run[first].op));
            check("m_ff_expected", first_fail_expected, (first < 0) ? 64'd0 : 64'(m_run[first].rv));
            check("m_ff_actual", first_fail_actual, (first < 0) ? 64'd0 : 64'(m_run[first].rd));
        end
    end

    // ---------------- stimulus helpers (enter and leave at a negedge) ----------------
    task automatic do_start(input int nv, input logic [7:0] mask);
        start            = 1'b1;
        num_vectors      = N_W'(nv);
        c_out_check_mask = mask;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] rd, input logic cd,
                        input logic [W-1:0] rv, input logic cv);
        sample_valid  = 1'b1;
        operation     = op;
        result_dut    = rd;
        c_out_dut     = cd;
        result_verify = rv;
        c_out_verify  = cv;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; num_vectors = '0; c_out_check_mask = '0;
        sample_valid = 1'b0; operation = '0; result_dut = '0; c_out_dut = 1'b0;
        result_verify = '0; c_out_verify = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_vc", vector_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-run
        do_start(8, 8'hFF);
        send(3'd0, 32'h1, 1'b0, 32'h2, 1'b0);
        send(3'd0, 32'h3, 1'b0, 32'h3, 1'b0);
        send(3'd0, 32'h4, 1'b0, 32'h4, 1'b0);
        check("mid_busy_before", busy, 1);
        check("mid_vc_before", vector_count, 3);
        check("mid_fc_before", fail_count, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_vc", vector_count, 0);
        check("async_fc", fail_count, 0);
        check("async_ff_actual", first_fail_actual, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean run
        do_start(4, 8'hFF);
        check("clean_busy_after_start", busy, 1);
        for (int i = 0; i < 4; i++) send(3'(i), 32'(i * 7), 1'b1, 32'(i * 7), 1'b1);
        check("clean_done", done, 1);
        check("clean_pass", pass, 1);
        check("clean_vc", vector_count, 4);
        check("clean_fc", fail_count, 0);

        // First-fail capture (restart straight from DONE)
        do_start(5, 8'h00);
        check("restart_vc_cleared", vector_count, 0);
        send(3'b010, 32'h0000_0009, 1'b0, 32'h0000_0009, 1'b0);
        send(3'b010, 32'h0000_0005, 1'b0, 32'h0000_0004, 1'b0);
        send(3'b010, 32'h0000_0010, 1'b0, 32'h0000_0010, 1'b0);
        send(3'b010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0);
        send(3'b010, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0);
        check("ff_done", done, 1);
        check("ff_fc", fail_count, 2);
        check("ff_index", first_fail_index, 1);
        check("ff_op", first_fail_op, 3'b010);
        check("ff_expected", first_fail_expected, 32'h4);
        check("ff_actual", first_fail_actual, 32'h5);
        check("ff_pass", pass, 0);
        // Samples while DONE are ignored
        send(3'b010, 32'h1, 1'b0, 32'h2, 1'b0);
        check("done_ignore_vc", vector_count, 5);
        check("done_ignore_fc", fail_count, 2);

        // Carry masking
        do_start(2, 8'b0000_0011);
        send(3'b101, 32'h7, 1'b1, 32'h7, 1'b0);
        check("carry_masked_fc", fail_count, 0);
        send(3'b001, 32'h7, 1'b1, 32'h7, 1'b0);
        check("carry_checked_fc", fail_count, 1);
        check("carry_done", done, 1);
        check("carry_ff_op", first_fail_op, 3'b001);

        // Zero-length run
        do_start(0, 8'h00);
        check("zero_done", done, 1);
        check("zero_pass", pass, 1);
        check("zero_busy", busy, 0);

        // Stalls and start during RUN
        do_start(3, 8'hFF);
        send(3'd4, 32'hA, 1'b0, 32'hA, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; num_vectors = N_W'(1);
        @(negedge clk);
        start = 1'b0;
        check("stall_busy", busy, 1);
        check("stall_vc", vector_count, 1);
        send(3'd4, 32'hB, 1'b0, 32'hB, 1'b0);
        @(negedge clk);
        check("stall_not_done", done, 0);
        send(3'd4, 32'hC, 1'b0, 32'hC, 1'b0);
        check("stall_done", done, 1);
        check("stall_vc_final", vector_count, 3);
        check("stall_pass", pass, 1);

        // Back-to-back samples every cycle
        do_start(6, 8'hFF);
        for (int i = 0; i < 6; i++)
            send(3'(i), 32'(i), 1'(i % 2), 32'((i == 4) ? 99 : i), 1'(i % 2));
        check("b2b_fc", fail_count, 1);
        check("b2b_index", first_fail_index, 4);
        check("b2b_expected", first_fail_expected, 99);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Self-checking comparator that closes the ALU verification loop. It receives the registered outputs of the behavioral verification ALU and the registered outputs of the ALU under test for the same stimulus, and compares them over a programmed run of vectors. It counts mismatches, captures the first failing vector, and reports pass/fail at the end of the run. It sits beside the verification ALU on the board or bench, downstream of both output registers.

## Interface

Parameters:
- W, 32, data width of both ALU results.
- N_W, 16, width of the vector-count, fail-count and index fields.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse that begins a run; sampled in IDLE and DONE only.
- num_vectors  input  N_W  number of samples in the run; captured on the accepted start.
- c_out_check_mask  input  8  bit k = 1 compares carry for operation k; bit k = 0 ignores carry for that operation. Captured on start.
- sample_valid  input  1  the result inputs hold a valid, aligned pair this cycle.
- operation  input  3  operation code that produced the current sample.
- result_dut  input  W  ALU-under-test result.
- c_out_dut  input  1  ALU-under-test carry.
- result_verify  input  W  verification ALU result.
- c_out_verify  input  1  verification ALU carry.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when fail_count == 0.
- vector_count  output  N_W  samples accepted in the current or last run.
- fail_count  output  N_W  mismatching samples; saturates at all-ones.
- first_fail_index  output  N_W  vector_count value of the first mismatch.
- first_fail_op  output  3  operation of the first mismatch.
- first_fail_expected  output  W  result_verify of the first mismatch.
- first_fail_actual  output  W  result_dut of the first mismatch.

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1:
  - If num_vectors == 0, go to DONE.
  - Otherwise go to RUN.
  - In both cases, clear vector_count, fail_count and all first_fail_* fields, and capture num_vectors and the mask.
- DONE, start=1: same action as in IDLE. This is a back-to-back restart.
- DONE with no start: hold all results.
- RUN, start=1: ignored.
- sample_valid in IDLE or DONE: ignored, with no counter change.
- Accepted sample: sample_valid=1 in RUN.
  - mismatch = (result_dut != result_verify) | (c_out_check_mask[operation] & (c_out_dut != c_out_verify)).
  - vector_count increments by 1.
  - On mismatch, fail_count increments, saturating at 2^N_W - 1.
  - When a mismatch occurs with fail_count == 0, load first_fail_index with the pre-increment vector_count. Load first_fail_op, first_fail_expected and first_fail_actual from the current inputs.
  - Later mismatches do not change the first_fail_* fields.
- End of run: when the accepted sample is the final one (vector_count == captured num_vectors - 1), go to DONE on the same edge.
- pass is computed in the registered domain: done & (fail_count == 0).
- Reset values: busy=0, done=0, pass=0, and every count and capture field is 0.

## Timing

- All outputs are registered. Nothing is combinational from the inputs.
- A start accepted at edge n gives busy=1 (or done=1 when num_vectors == 0) after edge n. Counters read 0 after the same edge.
- A sample accepted at edge n is reflected in vector_count, fail_count and first_fail_* after edge n, which is 1-cycle latency.
- On the final sample at edge n, done=1 and busy=0 after edge n. pass is valid in that same cycle.
- No throughput limit: sample_valid may be high every cycle.
- Gaps in sample_valid stall the count. There is no timeout.
- rst_n asserted mid-run forces IDLE and clears all outputs immediately, without waiting for clk.
- rst_n deasserts synchronously to clk. The first start is accepted no earlier than the first edge with rst_n=1.

## Test plan

- Reset mid-run: start with num_vectors=8, accept 3 samples, pull rst_n low between edges -> all outputs go to 0 at once, with no clock edge. After release, state is IDLE and start works normally.
- Clean run: num_vectors=4, four matching samples on consecutive cycles -> done=1 and pass=1 one cycle after the 4th sample. vector_count=4, fail_count=0.
- First-fail capture: num_vectors=5, op=3'b010.
  - Sample 1 (index 1) has result_dut=0x0000_0005 and result_verify=0x0000_0004.
  - Sample 3 also mismatches.
  - Required: fail_count=2, first_fail_index=1, first_fail_expected=0x4, first_fail_actual=0x5, pass=0.
- Carry masking: mask=8'b0000_0011, a sample with op=3'b101, equal results and differing carry -> no fail. The same carry difference with op=3'b001 -> fail_count=1.
- Boundary and stalls:
  - num_vectors=0 -> done=1 and pass=1 one cycle after start.
  - num_vectors=3 with sample_valid gaps, plus start pulsed during RUN -> the start is ignored and done rises after the 3rd valid sample.
  - A restart from DONE clears the counters.
